bus_control_multi: RTL
======================

BUS_CONTROL_MULTI -- requirements
Module: bus_control_multi

Interface
REQ-001 SHALL have parameter PROM_WAIT, default 2, meaning wait clocks before DTACK for PROM accesses.
REQ-002 SHALL have parameter SRAM_WAIT, default 0, meaning wait clocks before DTACK for SRAM accesses.
REQ-003 SHALL have parameter IO_WAIT, default 1, meaning wait clocks before DTACK for I/O accesses.
REQ-004 SHALL have parameter OUT_PORTS, default 2 (range 1..8), meaning the number of 8-bit output ports.
REQ-005 SHALL have parameter BERR_CYCLES, default 64, meaning clocks from request to BERR on an unmapped access.
REQ-006 SHALL have port CPUCLK_IN, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port RESET_IN, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports STEPEN_IN, STEP_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, each input, 1, all active-high: step enable, step switch, address strobe, write, upper and lower data strobes.
REQ-009 SHALL have ports ADDR_IN, input, 24, CPU address, and DATA_IN, input, 16, CPU write data.
REQ-010 SHALL have ports DTACK and BERR, each output, 1, registered data acknowledge and bus error.
REQ-011 SHALL have ports PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, IOCS and OE, each output, 1, combinational selects: even, odd, I/O and output enable.
REQ-012 SHALL have port OUTPUT_SIGNAL, output, 8*OUT_PORTS, output port registers, with port i in bits [8i+7:8i].
REQ-013 SHALL have port BOOTSTRAPPED, output, 1, boot overlay exited.

Function
REQ-014 SHALL decode regions from ADDR_IN[23:20]:
- 0xF: PROM.
- 0x1: I/O.
- 0x0: SRAM when WR_IN or BOOTSTRAPPED is high, otherwise PROM.
- All other values: unmapped.
REQ-015 SHALL drive the selects combinationally with ASREQ = AS_IN & ~RESET_IN:
- xxxCS0 = ASREQ & region & UDS_IN.
- xxxCS1 = ASREQ & region & LDS_IN.
- IOCS = ASREQ & I/O.
- OE = ASREQ & (PROM|SRAM) & ~WR_IN.
REQ-016 SHALL define the data request as DTREQ = AS_IN & (UDS_IN|LDS_IN).
REQ-017 SHALL treat as unmapped any I/O access whose address is not 0x100001+2i for some i<OUT_PORTS.
REQ-018 SHALL implement an FSM with the states IDLE, WAIT, STEP, ACK, RELEASE and BERR.
REQ-019 SHALL, in IDLE, when DTREQ is sampled, latch the region and load the wait counter, then:
- go to BERR-timing WAIT if unmapped;
- go to WAIT if the counter is nonzero;
- otherwise go to STEP or ACK, per REQ-021.
REQ-020 SHALL, in WAIT, decrement the counter each clock and leave WAIT on the edge where it reaches 0, so that DTACK rises exactly N+1 edges after DTREQ is first sampled (N = region wait).
REQ-021 SHALL go from wait completion to STEP when STEPEN_IN=1, holding DTACK=0 until STEP_IN is sampled high, and otherwise go to ACK.
REQ-022 SHALL assert DTACK in ACK until the edge at which ~DTREQ is sampled, then go to RELEASE if stepping, else IDLE.
REQ-023 SHALL hold RELEASE until STEP_IN is sampled low, then go to IDLE, so that one press acknowledges exactly one bus cycle.
REQ-024 SHALL, for an unmapped access, count BERR_CYCLES clocks from the first DTREQ sample, then assert BERR and hold it until ~DTREQ, with DTACK never asserted.
REQ-025 SHALL cancel any state and return to IDLE if DTREQ drops in WAIT or STEP (aborted cycle), with no side effects.
REQ-026 SHALL, for an I/O write with LDS_IN=1 to port i, load DATA_IN[7:0] into port i on the edge entering ACK; UDS-only writes SHALL have no effect.
REQ-027 SHALL set BOOTSTRAPPED on the edge entering ACK for a write to region 0x0, and clear it only by reset.

Reset
REQ-028 SHALL, while RESET_IN is sampled high, set:
- FSM=IDLE and counters=0;
- DTACK=0 and BERR=0;
- OUTPUT_SIGNAL=0 and BOOTSTRAPPED=0.
REQ-029 SHALL apply reset mid-cycle, which aborts the cycle, and SHALL NOT re-acknowledge that same cycle after reset releases until DTREQ falls and rises again.

Configuration
REQ-030 SHALL compile the STEP and RELEASE states and the STEPEN_IN/STEP_IN logic only with BUS_CONTROL_STEPPER_EN defined; without the macro these ports SHALL remain but be ignored, and wait completion SHALL go directly to ACK.

Structure
REQ-031 SHALL place the region enum, the FSM state encoding and the address constants (0x0, 0x1, 0xF, I/O base 0x100001) in the shared package bus_control_pkg.
REQ-032 SHALL implement the decode of REQ-014/REQ-017 in one combinational sub-module, bus_decode; the FSM, counters and registers SHALL stay in the top module.

Verification
REQ-033 SHALL cover: SRAM read 0x000100, SRAM_WAIT=0 -> DTACK high 1 edge after DTREQ, low 1 edge after AS falls; OE=1, SRAMCS0/1 follow UDS/LDS.
REQ-034 SHALL cover: PROM read 0xF00000, PROM_WAIT=2 -> DTACK rises on the 3rd edge; PROMCS0/1=1.
REQ-035 SHALL cover: after reset, read 0x000000 -> PROMCS; write 0x000000 -> SRAMCS and BOOTSTRAPPED=1; next read 0x000000 -> SRAMCS.
REQ-036 SHALL cover: byte write 0xA5 to 0x100003 -> OUTPUT_SIGNAL[15:8]=0xA5, port 0 unchanged; write 0x100005 with OUT_PORTS=2 -> BERR after 64 clocks, no DTACK.
REQ-037 SHALL cover, with BUS_CONTROL_STEPPER_EN and STEPEN_IN=1: DTACK stays 0 for 100 clocks; STEP_IN pulse -> one DTACK; STEP_IN held across the next cycle -> no second DTACK until STEP_IN is released and pressed again.

Source files
------------

// File: rtl/bus_control_pkg.sv
// Shared types and address constants for the 68k-style bus controller.
// Pure declarations, no logic and no latency.
// No flow control: consumed by the decoder and the bus-cycle FSM.
package bus_control_pkg;

  // Decoded target of the current bus cycle
  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_PROM = 2'd1,
    REGION_SRAM = 2'd2,
    REGION_IO   = 2'd3
  } region_t;

  // Bus-cycle FSM encoding; ST_STEP and ST_RELEASE are only reachable
  // when the single-step feature is compiled in
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STEP    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_BERR    = 3'd5
  } state_t;

  // ADDR[23:20] values selecting each region
  localparam logic [3:0]  AREA_LOW  = 4'h0;
  localparam logic [3:0]  AREA_IO   = 4'h1;
  localparam logic [3:0]  AREA_PROM = 4'hF;

  // Output port 0 lives here; port i is at IO_BASE + 2*i (odd byte lane)
  localparam logic [23:0] IO_BASE   = 24'h100001;

endpackage

// File: rtl/bus_decode.sv
// Address decoder: maps CPU address/direction to a region and output-port index.
// Latency: purely combinational.
// Backpressure: none; the FSM samples the result when it accepts a cycle.
module bus_decode
  import bus_control_pkg::*;
#(
  parameter int OUT_PORTS = 2
) (
  input  logic [23:0] addr_in,
  input  logic        wr_in,
  input  logic        boot_in,
  output region_t     region_o,
  output logic [2:0]  port_o
);

  logic [23:0] io_off;
  logic        io_ok;

  // Region select; the low area is the PROM boot overlay until the first write
  always_comb begin
    io_off   = addr_in - IO_BASE;
    // Offset must be even and index an existing port; addresses below the
    // base wrap to a huge offset and fail the compare
    io_ok    = ~io_off[0] && (io_off[23:1] < 23'(OUT_PORTS));
    port_o   = io_off[3:1];
    region_o = REGION_NONE;
    case (addr_in[23:20])
      AREA_PROM: region_o = REGION_PROM;
      AREA_IO:   region_o = io_ok ? REGION_IO : REGION_NONE;
      AREA_LOW:  region_o = (wr_in || boot_in) ? REGION_SRAM : REGION_PROM;
      default:   region_o = REGION_NONE;
    endcase
  end

endmodule

// File: rtl/bus_control_multi.sv
// Bus controller: chip selects, wait-state DTACK, BERR timeout, output ports.
// Latency: DTACK rises N+1 edges after DTREQ is first sampled (N = region wait).
// Backpressure: CPU is held by withholding DTACK; optional single-step gating
// compiled in with BUS_CONTROL_STEPPER_EN.
module bus_control_multi
  import bus_control_pkg::*;
#(
  parameter int PROM_WAIT   = 2,
  parameter int SRAM_WAIT   = 0,
  parameter int IO_WAIT     = 1,
  parameter int OUT_PORTS   = 2,
  parameter int BERR_CYCLES = 64
) (
  input  logic                   CPUCLK_IN,
  input  logic                   RESET_IN,
  input  logic                   STEPEN_IN,
  input  logic                   STEP_IN,
  input  logic                   AS_IN,
  input  logic                   WR_IN,
  input  logic                   UDS_IN,
  input  logic                   LDS_IN,
  input  logic [23:0]            ADDR_IN,
  input  logic [15:0]            DATA_IN,
  output logic                   DTACK,
  output logic                   BERR,
  output logic                   PROMCS0,
  output logic                   PROMCS1,
  output logic                   SRAMCS0,
  output logic                   SRAMCS1,
  output logic                   IOCS,
  output logic                   OE,
  output logic [8*OUT_PORTS-1:0] OUTPUT_SIGNAL,
  output logic                   BOOTSTRAPPED
);

  localparam int CNT_W = 16;

  state_t                 state_q, state_d;
  region_t                region_q, region_d;
  logic [2:0]             port_q, port_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dtack_q, dtack_d;
  logic                   berr_q, berr_d;
  logic [8*OUT_PORTS-1:0] out_q, out_d;
  logic                   boot_q, boot_d;
  // Set by reset; blocks a cycle still in flight at reset from being accepted
  logic                   block_q, block_d;

  region_t                dec_region;
  logic [2:0]             dec_port;
  logic                   dtreq, asreq;
  logic [CNT_W-1:0]       cnt_load;
  state_t                 done_idle, done_wait;
  logic                   ack_entry;
  logic                   unused_inputs;

  bus_decode #(.OUT_PORTS(OUT_PORTS)) u_decode (
    .addr_in  (ADDR_IN),
    .wr_in    (WR_IN),
    .boot_in  (boot_q),
    .region_o (dec_region),
    .port_o   (dec_port)
  );

`ifdef BUS_CONTROL_STEPPER_EN
  assign unused_inputs = ^DATA_IN[15:8];
`else
  assign unused_inputs = ^{DATA_IN[15:8], STEPEN_IN, STEP_IN};
`endif

  // Chip selects follow the live address so memories see them without delay
  always_comb begin
    dtreq   = AS_IN & (UDS_IN | LDS_IN);
    asreq   = AS_IN & ~RESET_IN;
    PROMCS0 = asreq & (dec_region == REGION_PROM) & UDS_IN;
    PROMCS1 = asreq & (dec_region == REGION_PROM) & LDS_IN;
    SRAMCS0 = asreq & (dec_region == REGION_SRAM) & UDS_IN;
    SRAMCS1 = asreq & (dec_region == REGION_SRAM) & LDS_IN;
    IOCS    = asreq & (dec_region == REGION_IO);
    OE      = asreq & ((dec_region == REGION_PROM) || (dec_region == REGION_SRAM)) & ~WR_IN;
  end

  // Wait count for a new cycle and where the cycle goes once waiting is over
  always_comb begin
    case (dec_region)
      REGION_PROM: cnt_load = CNT_W'(PROM_WAIT);
      REGION_SRAM: cnt_load = CNT_W'(SRAM_WAIT);
      REGION_IO:   cnt_load = CNT_W'(IO_WAIT);
      default:     cnt_load = CNT_W'(BERR_CYCLES);
    endcase
    done_idle = ST_ACK;
    done_wait = ST_ACK;
    if (dec_region == REGION_NONE) begin
      done_idle = ST_BERR;
    end
`ifdef BUS_CONTROL_STEPPER_EN
    else if (STEPEN_IN) begin
      done_idle = ST_STEP;
    end
`endif
    if (region_q == REGION_NONE) begin
      done_wait = ST_BERR;
    end
`ifdef BUS_CONTROL_STEPPER_EN
    else if (STEPEN_IN) begin
      done_wait = ST_STEP;
    end
`endif
  end

  // Bus-cycle FSM next state
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    port_d   = port_q;
    cnt_d    = cnt_q;
    block_d  = block_q & dtreq;
    case (state_q)
      ST_IDLE: begin
        if (dtreq && !block_q) begin
          region_d = dec_region;
          port_d   = dec_port;
          cnt_d    = cnt_load;
          state_d  = (cnt_load == '0) ? done_idle : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!dtreq) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = done_wait;
          end
        end
      end
`ifdef BUS_CONTROL_STEPPER_EN
      ST_STEP: begin
        if (!dtreq) begin
          state_d = ST_IDLE;
        end else if (STEP_IN) begin
          state_d = ST_ACK;
        end
      end
      ST_RELEASE: begin
        // One press acknowledges one cycle: wait for the switch to open
        if (!STEP_IN) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_ACK: begin
        if (!dtreq) begin
`ifdef BUS_CONTROL_STEPPER_EN
          state_d = STEPEN_IN ? ST_RELEASE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_BERR: begin
        if (!dtreq) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered strobes and write side effects taken on the edge entering ACK
  always_comb begin
    dtack_d   = (state_d == ST_ACK);
    berr_d    = (state_d == ST_BERR);
    ack_entry = (state_d == ST_ACK) && (state_q != ST_ACK);
    out_d     = out_q;
    boot_d    = boot_q;
    if (ack_entry && WR_IN) begin
      if (region_d == REGION_SRAM) begin
        boot_d = 1'b1;
      end
      if ((region_d == REGION_IO) && LDS_IN) begin
        for (int i = 0; i < OUT_PORTS; i++) begin
          if (port_d == 3'(i)) begin
            out_d[8*i +: 8] = DATA_IN[7:0];
          end
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state_q  <= ST_IDLE;
      region_q <= REGION_NONE;
      port_q   <= '0;
      cnt_q    <= '0;
      dtack_q  <= 1'b0;
      berr_q   <= 1'b0;
      out_q    <= '0;
      boot_q   <= 1'b0;
      block_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      port_q   <= port_d;
      cnt_q    <= cnt_d;
      dtack_q  <= dtack_d;
      berr_q   <= berr_d;
      out_q    <= out_d;
      boot_q   <= boot_d;
      block_q  <= block_d;
    end
  end

  assign DTACK         = dtack_q;
  assign BERR          = berr_q;
  assign OUTPUT_SIGNAL = out_q;
  assign BOOTSTRAPPED  = boot_q;

endmodule
